// File: rtl/tx_uart_if_if.sv
// tx_uart_if_if: parity type shared with the receiver, and the valid/ready byte channel into the transmitter.
package uart_pkg;
    typedef enum logic [1:0] {NO_PARITY = 2'd0, EVEN_PARITY = 2'd1, ODD_PARITY = 2'd2} parity_t;
endpackage

interface tx_uart_if_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/tx_uart_if.sv
// tx_uart_if: UART transmitter (start, 5-8 data bits LSB first, optional parity, 1-2 stop bits).
// Defining TX_UART_BUFFER_EN adds a one-byte holding register for gapless back-to-back frames.
module tx_uart_if #(
    parameter int SAMPLE_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] samples_per_bit,
    input  logic [3:0]              data_width,
    input  logic [1:0]              stop_bits,
    input  uart_pkg::parity_t       parity,
    tx_uart_if_if.slave             bus,
    output logic                    tx_out,
    output logic                    busy,
    output logic [3:0]              state_o
);
    import uart_pkg::*;

    typedef enum logic [3:0] {IDLE = 4'd0, START = 4'd1, DATA = 4'd2, PARITY = 4'd3, STOP = 4'd4} state_t;
    typedef struct packed {
        logic [7:0]              data;
        logic [2:0]              last;
        logic                    stop2;
        parity_t                 par;
        logic [SAMPLE_WIDTH-1:0] spb;
    } frame_t;

    state_t                  st_q, st_d;
    frame_t                  fr_q, fr_d, in_cfg;
    logic [SAMPLE_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]              bit_q, bit_d;
    logic                    stp_q, stp_d, tx_q, tx_d, rdy_q, rdy_d;
    logic                    cap, tick, take, pbit;
`ifdef TX_UART_BUFFER_EN
    frame_t                  hold_q, hold_d;
    logic                    full_q, full_d;
`endif

    // Input configuration normalised once at capture so the frame never sees out-of-range values.
    always_comb begin
        in_cfg.data  = bus.data;
        in_cfg.last  = data_width < 4'd5 ? 3'd4 : data_width > 4'd8 ? 3'd7 : 3'(data_width - 4'd1);
        in_cfg.stop2 = stop_bits[1];
        in_cfg.par   = parity;
        in_cfg.spb   = samples_per_bit == '0 ? SAMPLE_WIDTH'(1) : samples_per_bit;
    end

    assign bus.ready = rdy_q & enable & ~reset;
    assign cap       = bus.valid & bus.ready;
    assign tick      = cnt_q == fr_q.spb - SAMPLE_WIDTH'(1);

    always_comb begin
        st_d  = st_q;
        fr_d  = fr_q;
        cnt_d = cnt_q;
        bit_d = bit_q;
        stp_d = stp_q;
        take  = st_q == IDLE;
`ifdef TX_UART_BUFFER_EN
        hold_d = hold_q;
        full_d = full_q;
`endif
        if (st_q != IDLE) cnt_d = tick ? '0 : cnt_q + SAMPLE_WIDTH'(1);
        case (st_q)
            IDLE: if (cap) begin
                st_d  = START;
                fr_d  = in_cfg;
                cnt_d = '0;
            end
            START: if (tick) begin
                st_d  = DATA;
                bit_d = '0;
            end
            DATA: if (tick) begin
                bit_d = bit_q + 3'd1;
                stp_d = 1'b0;
                if (bit_q == fr_q.last) st_d = fr_q.par == NO_PARITY ? STOP : PARITY;
            end
            PARITY: if (tick) begin
                st_d  = STOP;
                stp_d = 1'b0;
            end
            STOP: if (tick) begin
                stp_d = 1'b1;
                if (stp_q || !fr_q.stop2) begin
                    st_d = IDLE;
`ifdef TX_UART_BUFFER_EN
                    // A byte waiting in (or arriving at) the end of the last stop bit starts immediately.
                    if (full_q) begin
                        st_d   = START;
                        fr_d   = hold_q;
                        full_d = 1'b0;
                    end else if (cap) begin
                        st_d = START;
                        fr_d = in_cfg;
                        take = 1'b1;
                    end
`endif
                end
            end
            default: st_d = IDLE;
        endcase
`ifdef TX_UART_BUFFER_EN
        if (cap && !take) begin
            hold_d = in_cfg;
            full_d = 1'b1;
        end
        rdy_d = !full_d;
`else
        rdy_d = st_d == IDLE;
`endif
        pbit = ^(fr_d.data & (8'hFF >> (3'd7 - fr_d.last))) ^ (fr_d.par == ODD_PARITY);
        tx_d = st_d == DATA ? fr_d.data[bit_d] : st_d == PARITY ? pbit : st_d != START;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= IDLE;
            fr_q   <= '0;
            cnt_q  <= '0;
            bit_q  <= '0;
            stp_q  <= 1'b0;
            tx_q   <= 1'b1;
            rdy_q  <= 1'b0;
`ifdef TX_UART_BUFFER_EN
            hold_q <= '0;
            full_q <= 1'b0;
`endif
        end else begin
            st_q   <= st_d;
            fr_q   <= fr_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            stp_q  <= stp_d;
            tx_q   <= tx_d;
            rdy_q  <= rdy_d;
`ifdef TX_UART_BUFFER_EN
            hold_q <= hold_d;
            full_q <= full_d;
`endif
        end
    end

    assign tx_out  = tx_q;
    assign busy    = st_q != IDLE;
    assign state_o = st_q;
endmodule

// File: tb/tb_tx_uart_if.sv
// tb_tx_uart_if: drives bytes through the handshake and compares the serial line against a per-cycle frame model.
module tb_tx_uart_if;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [31:0] spb = 32'd4;
    logic [3:0]  dw = 4'd8;
    logic [1:0]  sb = 2'd1;
    parity_t     par = NO_PARITY;
    logic        tx_out, busy;
    logic [3:0]  state_o;
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  pend[$];
    bit          exp_q[$];

    tx_uart_if_if bus();

    tx_uart_if dut (
        .clk(clk), .reset(reset), .enable(enable), .samples_per_bit(spb),
        .data_width(dw), .stop_bits(sb), .parity(par), .bus(bus),
        .tx_out(tx_out), .busy(busy), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    // Advance to the next falling edge and offer the head of the pending queue.
    task automatic cyc();
        @(negedge clk);
        if (pend.size() > 0) begin
            bus.valid = 1'b1;
            bus.data  = pend[0];
            if (bus.ready) void'(pend.pop_front());
        end else bus.valid = 1'b0;
    endtask

    task automatic wait_cap(input int target, output int left);
        int t = 0;
        while (pend.size() > target && t < 200) begin
            cyc();
            t++;
        end
        left = pend.size() - target;
    endtask

    // Reference frame: one entry per clk cycle, built from the frame rules.
    function automatic void add_frame(input logic [7:0] d, input int w_in, input int s_in, input int p, input int n_in);
        int w, s, n, ones;
        bit lv[$];
        w = w_in < 5 ? 5 : (w_in > 8 ? 8 : w_in);
        s = s_in == 0 ? 1 : (s_in >= 2 ? 2 : 1);
        n = n_in == 0 ? 1 : n_in;
        ones = 0;
        lv.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            lv.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (p == 1) lv.push_back(bit'(ones % 2));
        if (p == 2) lv.push_back(bit'((ones + 1) % 2));
        for (int i = 0; i < s; i++) lv.push_back(1'b1);
        foreach (lv[k]) repeat (n) exp_q.push_back(lv[k]);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        vectors++; if (tx_out !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx_out); end
        vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (state_o !== 4'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state_o); end
        reset = 1'b0;
        cyc();
        vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset: got %b want 1", bus.ready); end
    endtask

    task automatic test_frame(input logic [7:0] d, input int w, input int s, input int p, input int n,
                              input bit scramble, input string name);
        int bad = 0, first = -1, busy_n = 0, left;
        bit a = 1'b0;
        exp_q.delete();
        add_frame(d, w, s, p, n);
        dw = 4'(w); sb = 2'(s); par = parity_t'(p); spb = n;
        pend.push_back(d);
        wait_cap(0, left);
        vectors++; if (left !== 0) begin miscompares++; $display("FAIL %s capture: pending %0d want 0", name, left); pend.delete(); end
        for (int i = 0; i < exp_q.size(); i++) begin
            cyc();
            if (tx_out !== exp_q[i] && first < 0) begin first = i; a = tx_out; end
            if (tx_out !== exp_q[i]) bad++;
            if (busy === 1'b1) busy_n++;
            if (scramble && i == exp_q.size() / 2) begin
                spb = $urandom_range(1, 9); dw = 4'($urandom_range(0, 15));
                sb = 2'($urandom_range(0, 3)); par = parity_t'($urandom_range(0, 2));
                bus.data = 8'($urandom);
            end
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL %s wave: %0d bad cycles, first at %0d got %b want %b", name, bad, first, a, exp_q[first]); end
        vectors++; if (busy_n !== exp_q.size()) begin miscompares++; $display("FAIL %s busy: high %0d cycles want %0d", name, busy_n, exp_q.size()); end
        cyc();
        vectors++; if (tx_out !== 1'b1 || busy !== 1'b0 || state_o !== 4'd0) begin miscompares++; $display("FAIL %s idle: tx=%b busy=%b state=%0d want 1/0/0", name, tx_out, busy, state_o); end
    endtask

    task automatic test_reset_mid();
        int t = 0, left;
        dw = 4'd8; sb = 2'd1; par = NO_PARITY; spb = 4;
        pend.push_back(8'h00);
        wait_cap(0, left);
        while (state_o !== 4'd2 && t < 50) begin cyc(); t++; end
        cyc(); cyc();
        vectors++; if (state_o !== 4'd2 || tx_out !== 1'b0) begin miscompares++; $display("FAIL mid_data: state=%0d tx=%b want 2/0", state_o, tx_out); end
        reset = 1'b1;
        cyc();
        vectors++; if (tx_out !== 1'b1 || state_o !== 4'd0) begin miscompares++; $display("FAIL mid_reset: tx=%b state=%0d want 1/0", tx_out, state_o); end
        reset = 1'b0;
        test_frame(8'h55, 8, 1, 0, 4, 1'b0, "after_reset");
    endtask

    task automatic test_enable();
        int bad = 0, stray = 0, left;
        exp_q.delete();
        add_frame(8'h3C, 8, 1, 0, 3);
        dw = 4'd8; sb = 2'd1; par = NO_PARITY; spb = 3;
        pend.push_back(8'h3C);
        wait_cap(0, left);
        for (int i = 0; i < exp_q.size(); i++) begin
            cyc();
            if (tx_out !== exp_q[i]) bad++;
            if (i == 10) begin enable = 1'b0; pend.push_back(8'hC3); end
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL enable_frame: %0d bad cycles want 0", bad); end
        repeat (3 * exp_q.size()) begin
            cyc();
            if (tx_out !== 1'b1 || bus.ready !== 1'b0 || busy !== 1'b0) stray++;
        end
        vectors++; if (stray !== 0) begin miscompares++; $display("FAIL enable_gate: %0d active cycles want 0", stray); end
        pend.delete();
        enable = 1'b1;
        cyc();
    endtask

    task automatic test_back_to_back();
        int bad = 0, first = -1, left, gap;
`ifdef TX_UART_BUFFER_EN
        gap = 0;
`else
        gap = 1;
`endif
        exp_q.delete();
        add_frame(8'hA5, 8, 1, 0, 3);
        repeat (gap) exp_q.push_back(1'b1);
        add_frame(8'h5A, 8, 1, 0, 3);
        dw = 4'd8; sb = 2'd1; par = NO_PARITY; spb = 3;
        pend.push_back(8'hA5); pend.push_back(8'h5A);
        wait_cap(1, left);
        for (int i = 0; i < exp_q.size(); i++) begin
            cyc();
            if (tx_out !== exp_q[i] && first < 0) first = i;
            if (tx_out !== exp_q[i]) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL b2b_wave: %0d bad cycles, first at %0d want 0", bad, first); end
        vectors++; if (pend.size() !== 0) begin miscompares++; $display("FAIL b2b_accept: pending %0d want 0", pend.size()); end
        pend.delete();
        cyc();
        vectors++; if (busy !== 1'b0 || tx_out !== 1'b1) begin miscompares++; $display("FAIL b2b_idle: busy=%b tx=%b want 0/1", busy, tx_out); end
    endtask

    task automatic test_random();
        repeat (15)
            test_frame(8'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 2),
                       $urandom_range(0, 6), 1'($urandom_range(0, 1)), "random");
    endtask

    initial begin
        bus.valid = 1'b0;
        bus.data  = 8'h00;
        test_reset();
        test_frame(8'h55, 8, 1, 0, 434, 1'b0, "8N1");
        test_frame(8'h03, 7, 2, 1, 4, 1'b0, "7E2");
        test_frame(8'h03, 7, 2, 2, 4, 1'b0, "7O2");
        test_frame(8'hB6, 2, 0, 0, 5, 1'b0, "clamp");
        test_frame(8'hE1, 12, 3, 1, 0, 1'b0, "spb_zero");
        test_frame(8'h96, 8, 2, 1, 5, 1'b1, "cfg_change");
        test_reset_mid();
        test_back_to_back();
        test_enable();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
